// File: rtl/abs_squared_sum.sv
// abs_squared_sum: 3-stage |x|^2 = I^2 + Q^2 pipeline with valid/ready flow control and a frame counter.
// Define ABS_SQ_PEAK_EN to add a per-frame peak tracker (peakValue/peakIndex/peakValid).
module abs_squared_sum #(
    parameter  int DATA_WIDTH = 71,
    parameter  int FRAME_LEN  = 1024,
    localparam int OUT_WIDTH  = 2 * DATA_WIDTH,
    localparam int CW         = $clog2(FRAME_LEN)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] inputI,
    input  logic [DATA_WIDTH-1:0] inputQ,
    input  logic                  inValid,
    output logic                  inReady,
    output logic [OUT_WIDTH-1:0]  outputData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic                  outLast,
    output logic [OUT_WIDTH-1:0]  peakValue,
    output logic [CW-1:0]         peakIndex,
    output logic                  peakValid
);
    localparam int PW = 2 * DATA_WIDTH - 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic                  r_v1, r_v2, r_v3;
    logic [DATA_WIDTH-1:0] r_i, r_q;
    logic [PW-1:0]         r_ii, r_qq;
    logic [OUT_WIDTH-1:0]  r_sum;
    logic [CW-1:0]         r_count;
    logic [0:0]            r_state, w_state_next;

    logic                  w_adv, w_in_xfer, w_out_xfer;
    logic [DATA_WIDTH-1:0] w_abs_i, w_abs_q;
    logic [PW-1:0]         w_abs_i_ext, w_abs_q_ext;

    assign w_adv      = !r_v3 || outReady;
    assign inReady    = reset && w_adv;
    assign w_in_xfer  = inValid && inReady;
    assign w_out_xfer = r_v3 && outReady;

    // Squaring the magnitude equals squaring the signed value; -(-2^(W-1)) reads correctly as unsigned.
    assign w_abs_i     = r_i[DATA_WIDTH-1] ? -r_i : r_i;
    assign w_abs_q     = r_q[DATA_WIDTH-1] ? -r_q : r_q;
    assign w_abs_i_ext = {{(PW-DATA_WIDTH){1'b0}}, w_abs_i};
    assign w_abs_q_ext = {{(PW-DATA_WIDTH){1'b0}}, w_abs_q};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_v3  <= 1'b0;
            r_i   <= '0;
            r_q   <= '0;
            r_ii  <= '0;
            r_qq  <= '0;
            r_sum <= '0;
        end else if (w_adv) begin
            r_v1  <= w_in_xfer;
            r_i   <= inputI;
            r_q   <= inputQ;
            r_v2  <= r_v1;
            r_ii  <= w_abs_i_ext * w_abs_i_ext;
            r_qq  <= w_abs_q_ext * w_abs_q_ext;
            r_v3  <= r_v2;
            r_sum <= {1'b0, r_ii} + {1'b0, r_qq};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_out_xfer) begin
            r_count <= (r_count == LAST_IDX) ? '0 : r_count + 1'b1;
        end
    end

    assign outputData = r_sum;
    assign outValid   = r_v3;
    assign outLast    = r_v3 && (r_count == LAST_IDX);

    // Status-only FSM: tracks whether any sample occupies the pipeline.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_in_xfer) w_state_next = ST_STREAM;
            ST_STREAM: if (w_adv && !(w_in_xfer || r_v1 || r_v2)) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

`ifdef ABS_SQ_PEAK_EN
    logic [OUT_WIDTH-1:0] r_peak_run, r_peak_value;
    logic [CW-1:0]        r_peak_idx_run, r_peak_index;
    logic                 r_peak_valid;
    logic                 w_new_max;

    // Strict compare keeps the earliest index on ties.
    assign w_new_max = r_sum > r_peak_run;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_peak_run     <= '0;
            r_peak_idx_run <= '0;
            r_peak_value   <= '0;
            r_peak_index   <= '0;
            r_peak_valid   <= 1'b0;
        end else begin
            r_peak_valid <= 1'b0;
            if (w_out_xfer) begin
                if (r_count == LAST_IDX) begin
                    r_peak_value   <= w_new_max ? r_sum : r_peak_run;
                    r_peak_index   <= w_new_max ? r_count : r_peak_idx_run;
                    r_peak_valid   <= 1'b1;
                    r_peak_run     <= '0;
                    r_peak_idx_run <= '0;
                end else if (w_new_max) begin
                    r_peak_run     <= r_sum;
                    r_peak_idx_run <= r_count;
                end
            end
        end
    end

    assign peakValue = r_peak_value;
    assign peakIndex = r_peak_index;
    assign peakValid = r_peak_valid;
`else
    assign peakValue = '0;
    assign peakIndex = '0;
    assign peakValid = 1'b0;
`endif

endmodule

// File: tb/tb_abs_squared_sum.sv
// Testbench for abs_squared_sum (FRAME_LEN=4): scoreboard of expected magnitudes plus per-scenario checks.
module tb_abs_squared_sum;
    localparam int DW = 71;
    localparam int OW = 2 * DW;
    localparam int FL = 4;
    localparam int CW = $clog2(FL);

    logic                 clock = 1'b0;
    logic                 reset;
    logic signed [DW-1:0] inputI, inputQ;
    logic                 inValid, inReady;
    logic [OW-1:0]        outputData;
    logic                 outValid, outReady, outLast;
    logic [OW-1:0]        peakValue;
    logic [CW-1:0]        peakIndex;
    logic                 peakValid;

    always #5 clock = ~clock;

    abs_squared_sum #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
        .clock(clock), .reset(reset),
        .inputI(inputI), .inputQ(inputQ), .inValid(inValid), .inReady(inReady),
        .outputData(outputData), .outValid(outValid), .outReady(outReady), .outLast(outLast),
        .peakValue(peakValue), .peakIndex(peakIndex), .peakValid(peakValid)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    int            n_out   = 0;
    int            n_last  = 0;
    int            exp_cnt = 0;
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] sb_exp;

    function automatic logic [OW-1:0] mag(input logic signed [DW-1:0] i, input logic signed [DW-1:0] q);
        logic signed [OW-1:0] a, b;
        logic [OW-1:0]        r;
        a = i;
        b = q;
        r = a * a + b * b;
        return r;
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge clock) begin
        if (!reset) begin
            exp_q.delete();
            exp_cnt = 0;
        end else begin
            if (outValid && outReady) begin
                n_out++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got data=%0h, none expected", outputData);
                end else begin
                    sb_exp = exp_q.pop_front();
                    if (outputData !== sb_exp) begin
                        n_fail++;
                        $display("FAIL sb_data: got %0h, expected %0h", outputData, sb_exp);
                    end
                end
                n_tests++;
                if (outLast !== (exp_cnt == FL - 1)) begin
                    n_fail++;
                    $display("FAIL sb_last: got %0b, expected %0b (frame idx %0d)", outLast, exp_cnt == FL - 1, exp_cnt);
                end
                if (outLast) n_last++;
                exp_cnt = (exp_cnt + 1) % FL;
            end
            if (inValid && inReady) exp_q.push_back(mag(inputI, inputQ));
        end
    end

    task automatic send(input logic signed [DW-1:0] i, input logic signed [DW-1:0] q);
        logic ok;
        ok = 1'b0;
        inputI  = i;
        inputQ  = q;
        inValid = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clock);
            ok = inReady;
            @(posedge clock);
            #1;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: inReady=%0b, required 1 within 100 cycles", inReady);
        end
        $display("[TB] sent I=%0d Q=%0d", i, q);
    endtask

    task automatic idle();
        inValid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            @(posedge clock);
            #2;
            if (exp_q.size() == 0 && !outValid) break;
        end
        n_tests++;
        if (exp_q.size() != 0 || outValid) begin
            n_fail++;
            $display("FAIL drain: %0d results pending, required 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        n_tests++;
        if (outValid !== 1'b0 || outLast !== 1'b0 || inReady !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: outValid=%0b outLast=%0b inReady=%0b, required 0 0 0", outValid, outLast, inReady);
        end
        n_tests++;
        if (outputData !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %0h, required 0", outputData);
        end
        n_tests++;
        if (peakValid !== 1'b0 || peakValue !== '0 || peakIndex !== '0) begin
            n_fail++;
            $display("FAIL reset_peak: valid=%0b value=%0h index=%0d, required 0", peakValid, peakValue, peakIndex);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        n_tests++;
        if (inReady !== 1'b1) begin
            n_fail++;
            $display("FAIL release_ready: inReady=%0b, required 1", inReady);
        end
    endtask

    task automatic test_latency();
        int   lat;
        logic ready_ok;
        outReady = 1'b1;
        send(3, -4);
        idle();
        lat      = 1;
        ready_ok = 1'b1;
        while (!outValid && lat < 10) begin
            if (!inReady) ready_ok = 1'b0;
            @(posedge clock);
            #1;
            lat++;
        end
        n_tests++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles, required 3", lat);
        end
        n_tests++;
        if (outputData !== OW'(25)) begin
            n_fail++;
            $display("FAIL latency_data: got %0d, required 25", outputData);
        end
        n_tests++;
        if (!ready_ok) begin
            n_fail++;
            $display("FAIL latency_ready: inReady dropped, required to stay 1");
        end
        drain();
    endtask

    task automatic test_extremes();
        logic signed [DW-1:0] v_min, v_max;
        logic [OW-1:0]        e1, e2, one;
        int                   k;
        v_min = {1'b1, {(DW-1){1'b0}}};
        v_max = {1'b0, {(DW-1){1'b1}}};
        one   = 1;
        e1    = one << (OW - 1);
        e2    = e1 - (one << (DW + 1)) + OW'(2);
        send(v_min, v_min);
        send(v_max, v_max);
        idle();
        k = 0;
        while (!outValid && k < 10) begin
            @(posedge clock);
            #1;
            k++;
        end
        n_tests++;
        if (outputData !== e1) begin
            n_fail++;
            $display("FAIL extreme_min: got %0h, required %0h", outputData, e1);
        end
        @(posedge clock);
        #1;
        n_tests++;
        if (outputData !== e2 || outValid !== 1'b1) begin
            n_fail++;
            $display("FAIL extreme_max: got %0h valid=%0b, required %0h valid=1", outputData, outValid, e2);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int   out0;
        logic saw_stall;
        out0      = n_out;
        saw_stall = 1'b0;
        fork
            begin
                for (int k = 0; k < 8; k++) send(DW'(k * 1000 + 7), DW'(-k * 3));
                idle();
            end
            begin
                for (int c = 1; c <= 14; c++) begin
                    outReady = !(c >= 4 && c <= 8);
                    @(posedge clock);
                    #1;
                end
                outReady = 1'b1;
            end
            begin
                for (int c = 0; c < 16; c++) begin
                    @(negedge clock);
                    n_tests++;
                    if (inReady !== (!outValid || outReady)) begin
                        n_fail++;
                        $display("FAIL bp_ready: inReady=%0b, required %0b", inReady, !outValid || outReady);
                    end
                    if (!inReady) saw_stall = 1'b1;
                end
            end
        join
        drain();
        n_tests++;
        if (!saw_stall) begin
            n_fail++;
            $display("FAIL bp_stall: inReady never fell under backpressure");
        end
        n_tests++;
        if (n_out - out0 != 8) begin
            n_fail++;
            $display("FAIL bp_count: got %0d outputs, required 8", n_out - out0);
        end
    endtask

    task automatic test_frame();
        int last0, out0;
        do_reset();
        last0 = n_last;
        out0  = n_out;
        for (int k = 0; k < 9; k++) send(DW'(k + 1), DW'(k));
        idle();
        drain();
        n_tests++;
        if (n_last - last0 != 2 || n_out - out0 != 9) begin
            n_fail++;
            $display("FAIL frame_last: got %0d lasts in %0d outputs, required 2 in 9", n_last - last0, n_out - out0);
        end
    endtask

    task automatic test_reset_midflight();
        int last0;
        send(5, 6);
        send(-7, 8);
        idle();
        @(posedge clock);
        #1;
        n_tests++;
        if (outValid !== 1'b1) begin
            n_fail++;
            $display("FAIL midflight_pre: outValid=%0b, required 1", outValid);
        end
        #1 reset = 1'b0;
        #1;
        n_tests++;
        if (outValid !== 1'b0 || outputData !== '0 || inReady !== 1'b0 || outLast !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_async: valid=%0b data=%0h ready=%0b last=%0b, required all 0",
                     outValid, outputData, inReady, outLast);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        last0 = n_last;
        for (int k = 0; k < 4; k++) send(DW'(2 * k), DW'(-k));
        idle();
        drain();
        n_tests++;
        if (n_last - last0 != 1) begin
            n_fail++;
            $display("FAIL midflight_frame: got %0d lasts, required 1 on 4th sample", n_last - last0);
        end
    endtask

`ifdef ABS_SQ_PEAK_EN
    task automatic test_peak();
        logic found;
        do_reset();
        send(1, 0);
        send(3, 4);
        send(3, 0);
        send(0, 5);
        idle();
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clock);
            if (outValid && outReady && outLast) found = 1'b1;
        end
        @(posedge clock);
        #1;
        n_tests++;
        if (!found || peakValid !== 1'b1 || peakValue !== OW'(25) || peakIndex !== CW'(1)) begin
            n_fail++;
            $display("FAIL peak: found=%0b valid=%0b value=%0d index=%0d, required 1 1 25 1",
                     found, peakValid, peakValue, peakIndex);
        end
        @(posedge clock);
        #1;
        n_tests++;
        if (peakValid !== 1'b0) begin
            n_fail++;
            $display("FAIL peak_pulse: peakValid=%0b, required 0 after one cycle", peakValid);
        end
        drain();
    endtask
`else
    task automatic test_peak();
        do_reset();
        for (int k = 0; k < 4; k++) send(DW'(k + 3), DW'(k));
        idle();
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            n_tests++;
            if (peakValid !== 1'b0 || peakValue !== '0 || peakIndex !== '0) begin
                n_fail++;
                $display("FAIL peak_off: valid=%0b value=%0h index=%0d, required 0", peakValid, peakValue, peakIndex);
            end
        end
        drain();
    endtask
`endif

    initial begin
        reset    = 1'b0;
        inValid  = 1'b0;
        inputI   = '0;
        inputQ   = '0;
        outReady = 1'b1;
        test_reset();
        test_latency();
        test_extremes();
        test_back_to_back();
        test_frame();
        test_reset_midflight();
        test_peak();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
